// File: rtl/freq_monitor.sv
// freq_monitor: periodic sampling, boxcar averaging and debounced window classification of a count word
module freq_monitor #(
  parameter int CNTR_SIZE     = 10,
  parameter int AVG_LOG2      = 2,
  parameter int SAMPLE_PERIOD = 1024,
  parameter int LIMIT_LO      = 100,
  parameter int LIMIT_HI      = 900,
  parameter int DEBOUNCE      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNTR_SIZE-1:0] freq,
  input  logic                 alarm_clr,
  output logic                 sample_tick,
  output logic [CNTR_SIZE-1:0] avg,
  output logic                 avg_valid,
  output logic                 in_range,
  output logic                 too_low,
  output logic                 too_high,
  output logic                 alarm
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PW    = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int SW    = CNTR_SIZE + AVG_LOG2;
  localparam int TW    = $clog2(SAMPLE_PERIOD);
  localparam int CW    = $clog2(DEBOUNCE + 1);
  localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(DEPTH);
  typedef enum logic [1:0] {INIT, OK, LOW, HIGH} state_t;
  logic [TW-1:0]        timer;
  logic [CNTR_SIZE-1:0] smp [2**PW];
  logic [PW-1:0]        wr_ptr;
  logic [SW-1:0]        sum;
  logic [AVG_LOG2:0]    fill, fill_n;
  logic                 tick_d1, tick_d2, eval, sw;
  state_t               state, cand, cls;
  logic [CW-1:0]        cnt, cnt_inc;
  assign sample_tick = timer == TW'(SAMPLE_PERIOD - 1);
  assign fill_n      = fill == FULL ? fill : fill + (AVG_LOG2 + 1)'(1);
  assign eval        = tick_d2 & avg_valid;
  assign cls         = avg < CNTR_SIZE'(LIMIT_LO) ? LOW : avg > CNTR_SIZE'(LIMIT_HI) ? HIGH : OK;
  assign cnt_inc     = cls == cand ? cnt + CW'(1) : CW'(1);
  assign sw          = eval && cls != state && (state == INIT || cnt_inc >= CW'(DEBOUNCE));
  assign in_range    = state == OK;
  assign too_low     = state == LOW;
  assign too_high    = state == HIGH;
  // free-running sample period timer
  always_ff @(posedge clk)
    if (rst) timer <= '0;
    else timer <= sample_tick ? '0 : timer + TW'(1);
  // circular sample buffer with running sum; the oldest sample leaves as the new one enters
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 2**PW; i++) smp[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
    end else if (sample_tick) begin
      smp[wr_ptr] <= freq;
      sum         <= sum + SW'(freq) - SW'(smp[wr_ptr]);
      wr_ptr      <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
    end
  // average one cycle after the sample lands; valid once the buffer has been filled
  always_ff @(posedge clk)
    if (rst) begin
      tick_d1   <= 1'b0;
      tick_d2   <= 1'b0;
      avg       <= '0;
      fill      <= '0;
      avg_valid <= 1'b0;
    end else begin
      tick_d1 <= sample_tick;
      tick_d2 <= tick_d1;
      if (tick_d1) begin
        avg       <= CNTR_SIZE'(sum >> AVG_LOG2);
        fill      <= fill_n;
        avg_valid <= fill_n == FULL;
      end
    end
  // debounced classifier and sticky alarm; entry into LOW/HIGH beats a simultaneous clear
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT;
      cand  <= INIT;
      cnt   <= '0;
      alarm <= 1'b0;
    end else begin
      alarm <= (sw && cls != OK) || (alarm && !alarm_clr);
      if (eval) begin
        cand  <= cls;
        state <= sw ? cls : state;
        cnt   <= (sw || cls == state) ? '0 : cnt_inc;
      end
    end
endmodule

// File: tb/tb_freq_monitor.sv
// tb_freq_monitor: directed scoreboard bench for two freq_monitor configurations
module tb_freq_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] fq [2];
  logic       clr [2];
  logic       tk [2];
  logic [9:0] av [2];
  logic       vl [2];
  logic       ir [2];
  logic       tl [2];
  logic       th [2];
  logic       al [2];
  int total = 0;
  int bad = 0;
  int q[$];
  int win [2][4];
  int wp [2];
  int fill [2];
  int dep [2] = '{4, 1};

  always #5 clk = ~clk;

  freq_monitor #(.CNTR_SIZE(10), .AVG_LOG2(2), .SAMPLE_PERIOD(8), .LIMIT_LO(100), .LIMIT_HI(900), .DEBOUNCE(3)) u_a (
    .clk(clk), .rst(rst), .freq(fq[0]), .alarm_clr(clr[0]), .sample_tick(tk[0]), .avg(av[0]),
    .avg_valid(vl[0]), .in_range(ir[0]), .too_low(tl[0]), .too_high(th[0]), .alarm(al[0]));

  freq_monitor #(.CNTR_SIZE(10), .AVG_LOG2(0), .SAMPLE_PERIOD(8), .LIMIT_LO(100), .LIMIT_HI(900), .DEBOUNCE(3)) u_b (
    .clk(clk), .rst(rst), .freq(fq[1]), .alarm_clr(clr[1]), .sample_tick(tk[1]), .avg(av[1]),
    .avg_valid(vl[1]), .in_range(ir[1]), .too_low(tl[1]), .too_high(th[1]), .alarm(al[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++)
      chk({tag, "_outputs"}, {16'd0, tk[s], av[s], vl[s], ir[s], tl[s], th[s], al[s]}, 0);
    rst = 1'b0;
    q.delete();
    for (int s = 0; s < 2; s++) begin
      fill[s] = 0;
      wp[s] = 0;
      for (int j = 0; j < 4; j++) win[s][j] = 0;
    end
  endtask

  task automatic wait_tick(input int s, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tk[s] && n < 20);
    if (!tk[s]) chk("tick_seen", {31'd0, tk[s]}, 1);
  endtask

  task automatic samp(input int s, input int v, input int st_exp, input int al_exp,
                      input bit clr_entry = 1'b0, input int gap = -1);
    int n, sm;
    fq[s] = 10'(v);
    win[s][wp[s]] = v;
    wp[s] = (wp[s] + 1) % dep[s];
    if (fill[s] < dep[s]) fill[s]++;
    sm = 0;
    for (int j = 0; j < dep[s]; j++) sm += win[s][j];
    q.push_back(sm / dep[s]);
    wait_tick(s, n);
    if (gap >= 0) chk("tick_gap", n, gap);
    @(posedge clk);
    #1;
    chk("tick_pulse", {31'd0, tk[s]}, 0);
    @(posedge clk);
    #1;
    chk("avg", {22'd0, av[s]}, q.pop_front());
    chk("avg_valid", {31'd0, vl[s]}, {31'd0, fill[s] >= dep[s]});
    if (clr_entry) clr[s] = 1'b1;
    @(posedge clk);
    #1;
    clr[s] = 1'b0;
    chk("state", {29'd0, ir[s], tl[s], th[s]}, st_exp);
    chk("alarm", {31'd0, al[s]}, al_exp);
  endtask

  task automatic pulse_clr(input int s, input int st_exp, input int al_exp);
    clr[s] = 1'b1;
    @(posedge clk);
    #1;
    clr[s] = 1'b0;
    chk("clr_state", {29'd0, ir[s], tl[s], th[s]}, st_exp);
    chk("clr_alarm", {31'd0, al[s]}, al_exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    fq[0] = '0; fq[1] = '0; clr[0] = 1'b0; clr[1] = 1'b0;
    do_reset("rst0");
    fq[0] = 10'd500;
    samp(1, 500, 4, 0, 0, 8);
    samp(1, 950, 4, 0);
    samp(1, 500, 4, 0);
    samp(1, 950, 4, 0);
    samp(1, 950, 4, 0);
    samp(1, 950, 1, 1);
    samp(1, 50, 1, 1);
    samp(1, 950, 1, 1);
    samp(1, 50, 1, 1);
    samp(1, 50, 1, 1);
    samp(1, 50, 2, 1);
    samp(1, 100, 2, 1);
    samp(1, 100, 2, 1);
    samp(1, 100, 4, 1);
    pulse_clr(1, 4, 0);
    samp(1, 900, 4, 0);
    samp(1, 99, 4, 0);
    samp(1, 99, 4, 0);
    samp(1, 99, 2, 1);
    pulse_clr(1, 2, 0);
    samp(1, 901, 2, 0);
    samp(1, 901, 2, 0);
    samp(1, 901, 1, 1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    pulse_clr(1, 1, 0);
    samp(1, 901, 1, 0);
    do_reset("rst1");
    samp(0, 500, 0, 0, 0, 8);
    samp(0, 500, 0, 0, 0, 6);
    samp(0, 500, 0, 0, 0, 6);
    samp(0, 500, 4, 0, 0, 6);
    samp(0, 100, 4, 0);
    samp(0, 200, 4, 0);
    samp(0, 300, 4, 0);
    samp(0, 400, 4, 0);
    samp(0, 800, 4, 0);
    samp(0, 1, 4, 0);
    samp(0, 1, 4, 0);
    samp(0, 1, 4, 0);
    samp(0, 2, 4, 0);
    samp(0, 1023, 4, 0);
    samp(0, 1023, 4, 0);
    samp(0, 1023, 4, 0);
    samp(0, 1023, 4, 0);
    samp(0, 300, 4, 0);
    samp(0, 300, 4, 0);
    do_reset("rst2");
    samp(0, 700, 0, 0, 0, 8);
    samp(0, 700, 0, 0);
    samp(0, 700, 0, 0);
    samp(0, 700, 4, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
